// File: rtl/pong_engine.sv
// pong_engine: single-clock Pong game state, scoring and pixel colouring.
// Optional define PONG_AI_PADDLE_EN makes the right paddle follow the ball.
module pong_engine #(
    parameter int GRAPHICS_WIDTH   = 1280,
    parameter int GRAPHICS_HEIGHT  = 800,
    parameter int POSITION_REG_MAX = 11,
    parameter int BORDER_WIDTH     = 50,
    parameter int PADDLE_LENGTH    = 200,
    parameter int PADDLE_WIDTH     = 20,
    parameter int PADDLE_SPEED     = 10,
    parameter int PADDLE_INSET     = 60,
    parameter int BALL_SIZE        = 20,
    parameter int BALL_SPEED       = 4,
    parameter int WIN_SCORE        = 9,
    parameter int SERVE_FRAMES     = 60,
    parameter int SCORE_BITS       = 4
) (
    input  logic                    pixel_clock,
    input  logic                    reset,
    input  logic                    vga_vertical_sync,
    input  logic [POSITION_REG_MAX:0] h_position,
    input  logic [POSITION_REG_MAX:0] v_position,
    input  logic                    p1_up,
    input  logic                    p1_down,
    input  logic                    p2_up,
    input  logic                    p2_down,
    output logic [11:0]             rgb12,
    output logic [SCORE_BITS-1:0]   score_left,
    output logic [SCORE_BITS-1:0]   score_right,
    output logic                    game_over
);
    typedef logic [POSITION_REG_MAX:0]   pos_t;
    typedef logic [POSITION_REG_MAX+1:0] ext_t;
    typedef logic [SCORE_BITS-1:0]       score_t;
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    typedef logic [CNT_W-1:0]            cnt_t;
    typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_GAME_OVER} state_t;

    localparam pos_t BORDER        = pos_t'(BORDER_WIDTH);
    localparam pos_t RIGHT_EDGE    = pos_t'(GRAPHICS_WIDTH - BORDER_WIDTH);
    localparam pos_t BOTTOM_EDGE   = pos_t'(GRAPHICS_HEIGHT - BORDER_WIDTH);
    localparam pos_t BALL_X0       = pos_t'((GRAPHICS_WIDTH - BALL_SIZE) / 2);
    localparam pos_t BALL_Y0       = pos_t'((GRAPHICS_HEIGHT - BALL_SIZE) / 2);
    localparam pos_t BALL_W        = pos_t'(BALL_SIZE);
    localparam pos_t BALL_V        = pos_t'(BALL_SPEED);
    localparam pos_t BALL_X_MAX    = pos_t'(GRAPHICS_WIDTH - BORDER_WIDTH - BALL_SIZE);
    localparam pos_t BALL_Y_MAX    = pos_t'(GRAPHICS_HEIGHT - BORDER_WIDTH - BALL_SIZE);
    localparam pos_t BALL_TOP_TURN = pos_t'(BORDER_WIDTH + BALL_SPEED);
    localparam pos_t BALL_BOT_TURN = pos_t'(GRAPHICS_HEIGHT - BORDER_WIDTH - BALL_SIZE - BALL_SPEED);
    localparam pos_t PAD_Y0        = pos_t'((GRAPHICS_HEIGHT - PADDLE_LENGTH) / 2);
    localparam pos_t PAD_Y_MAX     = pos_t'(GRAPHICS_HEIGHT - BORDER_WIDTH - PADDLE_LENGTH);
    localparam pos_t PAD_UP_LIMIT  = pos_t'(BORDER_WIDTH + PADDLE_SPEED);
    localparam pos_t PAD_DN_LIMIT  = pos_t'(GRAPHICS_HEIGHT - BORDER_WIDTH - PADDLE_LENGTH - PADDLE_SPEED);
    localparam pos_t PAD_V         = pos_t'(PADDLE_SPEED);
    localparam pos_t PAD_W         = pos_t'(PADDLE_WIDTH);
    localparam pos_t PAD_LEN       = pos_t'(PADDLE_LENGTH);
    localparam pos_t LEFT_PAD_X    = pos_t'(PADDLE_INSET);
    localparam pos_t RIGHT_PAD_X   = pos_t'(GRAPHICS_WIDTH - PADDLE_INSET - PADDLE_WIDTH);
    localparam score_t WIN         = score_t'(WIN_SCORE);
    localparam cnt_t SERVE_LAST    = cnt_t'(SERVE_FRAMES - 1);

    function automatic logic covers(pos_t p, pos_t lo, pos_t size);
        return (p >= lo) && (ext_t'(p) < ext_t'(lo) + ext_t'(size));
    endfunction

    function automatic logic overlaps(pos_t a, pos_t a_size, pos_t b, pos_t b_size);
        return (ext_t'(a) < ext_t'(b) + ext_t'(b_size)) && (ext_t'(b) < ext_t'(a) + ext_t'(a_size));
    endfunction

    // Clamp tests are done before the subtraction so y never wraps below zero.
    function automatic pos_t step_paddle(pos_t y, logic up, logic down);
        pos_t r;
        r = y;
        if (up && !down)      r = (y < PAD_UP_LIMIT) ? BORDER : y - PAD_V;
        else if (down && !up) r = (y > PAD_DN_LIMIT) ? PAD_Y_MAX : y + PAD_V;
        return r;
    endfunction

    state_t state, state_next;
    cnt_t   serve_count, serve_count_next;
    pos_t   ball_x, ball_x_next, ball_y, ball_y_next;
    pos_t   pad_l, pad_l_next, pad_r, pad_r_next;
    logic   dx_neg, dx_neg_next, dy_neg, dy_neg_next;
    score_t score_l, score_l_next, score_r, score_r_next;
    logic   vsync_q, tick, hit, new_dx_neg;
    logic   right_up, right_down;
    logic [11:0] colour;

    assign tick        = vga_vertical_sync & ~vsync_q;
    assign game_over   = (state == ST_GAME_OVER);
    assign score_left  = score_l;
    assign score_right = score_r;

`ifdef PONG_AI_PADDLE_EN
    ext_t ball_centre, paddle_centre;
    assign ball_centre   = ext_t'(ball_y) + ext_t'(BALL_SIZE / 2);
    assign paddle_centre = ext_t'(pad_r) + ext_t'(PADDLE_LENGTH / 2);
    assign right_up      = (ball_centre + ext_t'(PADDLE_SPEED)) < paddle_centre;
    assign right_down    = ball_centre > (paddle_centre + ext_t'(PADDLE_SPEED));
`else
    assign right_up      = p2_up;
    assign right_down    = p2_down;
`endif

    always_comb begin
        state_next       = state;
        serve_count_next = serve_count;
        ball_x_next      = ball_x;
        ball_y_next      = ball_y;
        dx_neg_next      = dx_neg;
        dy_neg_next      = dy_neg;
        pad_l_next       = pad_l;
        pad_r_next       = pad_r;
        score_l_next     = score_l;
        score_r_next     = score_r;
        hit              = 1'b0;
        new_dx_neg       = dx_neg;
        if (tick) begin
            pad_l_next = step_paddle(pad_l, p1_up, p1_down);
            pad_r_next = step_paddle(pad_r, right_up, right_down);
            unique case (state)
                ST_SERVE: begin
                    ball_x_next = BALL_X0;
                    ball_y_next = BALL_Y0;
                    if (serve_count == SERVE_LAST) begin
                        state_next       = ST_PLAY;
                        serve_count_next = '0;
                    end else begin
                        serve_count_next = serve_count + cnt_t'(1);
                    end
                end
                ST_PLAY: begin
                    if (ball_x < BORDER || ball_x > BALL_X_MAX) begin
                        // Serve heads toward the player who just conceded.
                        if (ball_x < BORDER) begin
                            score_r_next = score_r + score_t'(1);
                            dx_neg_next  = 1'b1;
                        end else begin
                            score_l_next = score_l + score_t'(1);
                            dx_neg_next  = 1'b0;
                        end
                        ball_x_next      = BALL_X0;
                        ball_y_next      = BALL_Y0;
                        serve_count_next = '0;
                        state_next = (score_l_next == WIN || score_r_next == WIN) ? ST_GAME_OVER : ST_SERVE;
                    end else begin
                        hit = (dx_neg && overlaps(ball_x, BALL_W, LEFT_PAD_X, PAD_W)
                                      && overlaps(ball_y, BALL_W, pad_l, PAD_LEN))
                           || (!dx_neg && overlaps(ball_x, BALL_W, RIGHT_PAD_X, PAD_W)
                                       && overlaps(ball_y, BALL_W, pad_r, PAD_LEN));
                        new_dx_neg  = dx_neg ^ hit;
                        dx_neg_next = new_dx_neg;
                        ball_x_next = new_dx_neg ? ball_x - BALL_V : ball_x + BALL_V;
                        if (dy_neg) begin
                            if (ball_y <= BALL_TOP_TURN) begin
                                ball_y_next = BORDER;
                                dy_neg_next = 1'b0;
                            end else begin
                                ball_y_next = ball_y - BALL_V;
                            end
                        end else if (ball_y >= BALL_BOT_TURN) begin
                            ball_y_next = BALL_Y_MAX;
                            dy_neg_next = 1'b1;
                        end else begin
                            ball_y_next = ball_y + BALL_V;
                        end
                    end
                end
                ST_GAME_OVER: begin
                    if (p1_up || p1_down || p2_up || p2_down) begin
                        score_l_next     = '0;
                        score_r_next     = '0;
                        serve_count_next = '0;
                        state_next       = ST_SERVE;
                    end
                end
                default: state_next = ST_SERVE;
            endcase
        end
    end

    always_comb begin
        colour = 12'h000;
        if (covers(h_position, ball_x, BALL_W) && covers(v_position, ball_y, BALL_W))
            colour = 12'hfff;
        else if ((covers(h_position, LEFT_PAD_X, PAD_W) && covers(v_position, pad_l, PAD_LEN)) ||
                 (covers(h_position, RIGHT_PAD_X, PAD_W) && covers(v_position, pad_r, PAD_LEN)))
            colour = 12'hfff;
        else if (h_position < BORDER || h_position >= RIGHT_EDGE ||
                 v_position < BORDER || v_position >= BOTTOM_EDGE)
            colour = game_over ? 12'hf00 : 12'h303;
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            vsync_q     <= 1'b0;
            state       <= ST_SERVE;
            serve_count <= '0;
            ball_x      <= BALL_X0;
            ball_y      <= BALL_Y0;
            dx_neg      <= 1'b0;
            dy_neg      <= 1'b0;
            pad_l       <= PAD_Y0;
            pad_r       <= PAD_Y0;
            score_l     <= '0;
            score_r     <= '0;
            rgb12       <= 12'h000;
        end else begin
            vsync_q     <= vga_vertical_sync;
            state       <= state_next;
            serve_count <= serve_count_next;
            ball_x      <= ball_x_next;
            ball_y      <= ball_y_next;
            dx_neg      <= dx_neg_next;
            dy_neg      <= dy_neg_next;
            pad_l       <= pad_l_next;
            pad_r       <= pad_r_next;
            score_l     <= score_l_next;
            score_r     <= score_r_next;
            rgb12       <= colour;
        end
    end
endmodule
